// File: rtl/simple_computer_pkg.sv
// Shared definitions for the simple accumulator computer: opcode values,
// ULA operation codes, sequencer state encoding and default widths.
// Used by fetch_sequencer and instr_decoder.
package simple_computer_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_W       = 4;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'h7;

  typedef enum logic [1:0] {
    ULA_PASS,
    ULA_ADD,
    ULA_SUB,
    ULA_AND
  } ula_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } seq_state_e;

  // Opcodes with the top bit set are outside the instruction set.
  function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
    return ~op[OPC_W-1];
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// pc_counter: program counter register for fetch_sequencer.
// Clear has priority over load, load over increment; increment wraps
// modulo 2**ADDR_W. pc_nxt exposes the value the PC takes at the next edge.
module pc_counter
  import simple_computer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_nxt
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC selection: clear, load, increment, or hold.
  always_comb begin
    pc_d = pc_q;
    if (clear) begin
      pc_d = '0;
    end else if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign pc_nxt = pc_d;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch / control sequencer for the accumulator
// computer. Fetches a word, registers opcode and operand for instr_decoder,
// then strobes exec_en once and advances or loads the PC.
// Optional feature: define SEQ_BREAKPOINT_EN to add bp_en/bp_addr, which halt
// the sequencer before fetching from bp_addr; start then resumes at that PC.
module fetch_sequencer
  import simple_computer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SEQ_BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
`endif
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  operand_addr,
  input  logic               pc_load,
  output logic               exec_en,
  output logic               running,
  output logic               halted,
  output logic               illegal
);

  seq_state_e        state_q, state_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [ADDR_W-1:0] operand_q, operand_d;
  logic              illegal_q, illegal_d;
  logic              exec_en_q, exec_en_d;
  logic              imem_rd_q, imem_rd_d;
  logic              running_q, running_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              start_ok;
  logic              resume;
  logic              bp_stop;
  logic              pc_clr;
  logic              pc_ld;
  logic              pc_inc;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));

`ifdef SEQ_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;

  // Resuming after a breakpoint keeps the PC and skips the check once.
  assign resume  = start_ok && (state_q == ST_HALT) && bp_hit_q;
  assign bp_stop = bp_en && (pc_nxt == bp_addr);

  // Remember whether the current halt came from the breakpoint.
  always_comb begin
    bp_hit_d = bp_hit_q;
    if (start_ok || (state_q == ST_EXEC)) begin
      bp_hit_d = bp_stop && !resume;
    end
  end

  // Breakpoint-halt flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end
`else
  assign resume  = 1'b0;
  assign bp_stop = 1'b0;
`endif

  assign pc_clr = start_ok && !resume;
  assign pc_ld  = (state_q == ST_EXEC) && pc_load;
  assign pc_inc = (state_q == ST_EXEC) && !pc_load;

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pc_clr),
    .load     (pc_ld),
    .inc      (pc_inc),
    .load_val (operand_q),
    .pc       (pc),
    .pc_nxt   (pc_nxt)
  );

  // Next-state, instruction register and registered-output decode.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_ok) begin
          illegal_d = 1'b0;
          state_d   = (bp_stop && !resume) ? ST_HALT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          opcode_d  = imem_rdata[INSTR_W-1 -: OPC_W];
          operand_d = imem_rdata[ADDR_W-1:0];
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode_q == OP_NOP) begin
          state_d = ST_HALT;
        end else if (!opcode_legal(opcode_q)) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = bp_stop ? ST_HALT : ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    imem_rd_d = (state_d == ST_FETCH);
    exec_en_d = (state_d == ST_EXEC);
    running_d = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
    halted_d  = (state_d == ST_HALT);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      operand_q <= '0;
      illegal_q <= 1'b0;
      exec_en_q <= 1'b0;
      imem_rd_q <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      illegal_q <= illegal_d;
      exec_en_q <= exec_en_d;
      imem_rd_q <= imem_rd_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_addr    = pc;
  assign imem_rd      = imem_rd_q;
  assign opcode       = opcode_q;
  assign operand_addr = operand_q;
  assign exec_en      = exec_en_q;
  assign running      = running_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs push expected
// fetch/execute/halt events; a monitor pops and compares as the DUT emits them.
module tb_fetch_sequencer;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LOAD = 4'h1;
  localparam logic [3:0] OPC_ADD  = 4'h3;
  localparam logic [3:0] OPC_JZ   = 4'h6;
  localparam logic [3:0] OPC_JMP  = 4'h7;
  localparam int K_FETCH = 0;
  localparam int K_EXEC  = 1;
  localparam int K_HALT  = 2;

  typedef struct {
    int         kind;
    logic [11:0] addr;
    logic [3:0]  op;
    logic        ill;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        bp_en;
  logic [11:0] bp_addr;
  logic [11:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [3:0]  opcode;
  logic [11:0] operand_addr;
  logic        pc_load;
  logic        exec_en;
  logic        running;
  logic        halted;
  logic        illegal;

  logic [15:0] mem [0:4095];
  int          wait_cfg;
  int          wait_cnt;
  logic        acc_zero;
  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fetch = -1;
  int          rd_wait = 0;
  logic [11:0] last_addr = '0;
  logic        halted_prev = 1'b0;

  fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef SEQ_BREAKPOINT_EN
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
`endif
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .opcode       (opcode),
    .operand_addr (operand_addr),
    .pc_load      (pc_load),
    .exec_en      (exec_en),
    .running      (running),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with a programmable number of wait cycles.
  assign imem_rdata = mem[imem_addr];
  assign imem_valid = imem_rd && (wait_cnt >= wait_cfg);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_rd && !imem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Decoder model: jump on JMP, or on JZ when the accumulator is zero.
  assign pc_load = exec_en && ((opcode == OPC_JMP) || ((opcode == OPC_JZ) && acc_zero));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [11:0] addr, input logic [3:0] op, input logic ill);
    ev_t e;
    e.kind = kind; e.addr = addr; e.op = op; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic expect_event(input int kind, input logic [11:0] addr, input logic [3:0] op, input logic ill);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at addr %0h, expected no event", kind, addr);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_addr", addr, e.addr);
      if (e.kind == K_EXEC) check("exec_opcode", op, e.op);
      if (e.kind == K_HALT) check("halt_illegal", ill, e.ill);
    end
  endtask

  // Monitor: compares each fetch, execute strobe and halt entry against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_rd && !imem_valid) begin
        if (rd_wait > 0) check("fetch_addr_stable", imem_addr, last_addr);
        check("no_exec_during_fetch", exec_en, 1'b0);
        last_addr = imem_addr;
        rd_wait++;
      end
      if (imem_rd && imem_valid) begin
        check("fetch_wait_cycles", rd_wait, wait_cfg);
        if (wait_cfg == 0 && last_fetch >= 0) check("cycles_per_instr", cyc - last_fetch, 3);
        last_fetch = cyc;
        rd_wait = 0;
        expect_event(K_FETCH, imem_addr, 4'h0, 1'b0);
      end
      if (exec_en) expect_event(K_EXEC, imem_addr, opcode, 1'b0);
      if (halted && !halted_prev) begin
        expect_event(K_HALT, imem_addr, 4'h0, illegal);
        last_fetch = -1;
      end
      halted_prev = halted;
    end else begin
      halted_prev = 1'b0;
      rd_wait = 0;
      last_fetch = -1;
    end
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] a);
    return {op, a};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_rd"}, imem_rd, 0);
    check({tag, "_opcode"}, opcode, 0);
    check({tag, "_operand"}, operand_addr, 0);
    check({tag, "_exec_en"}, exec_en, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_illegal"}, illegal, 0);
  endtask

  task automatic run_prog(input string name);
    bit done;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_running_after_start"}, running, 1'b1);
    check({name, "_illegal_after_start"}, illegal, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (halted) done = 1'b1;
    end
    check({name, "_halt_reached"}, done, 1'b1);
    @(negedge clk);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; acc_zero = 1'b0; wait_cfg = 0;
    bp_en = 1'b0; bp_addr = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // LOAD 5, ADD 6, NOP
    mem[0] = ins(OPC_LOAD, 12'h005); mem[1] = ins(OPC_ADD, 12'h006); mem[2] = ins(OPC_NOP, 12'h000);
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_LOAD, 0);
    push_ev(K_FETCH, 12'h001, 0, 0); push_ev(K_EXEC, 12'h001, OPC_ADD, 0);
    push_ev(K_FETCH, 12'h002, 0, 0); push_ev(K_HALT, 12'h002, 0, 0);
    run_prog("basic");

    // JMP 0x010, NOP at 0x010
    clear_mem();
    mem[0] = ins(OPC_JMP, 12'h010);
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_JMP, 0);
    push_ev(K_FETCH, 12'h010, 0, 0); push_ev(K_HALT, 12'h010, 0, 0);
    run_prog("jmp");

    // JZ at 5, accumulator nonzero then zero
    clear_mem();
    mem[0] = ins(OPC_JMP, 12'h005); mem[5] = ins(OPC_JZ, 12'h020);
    acc_zero = 1'b0;
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_JMP, 0);
    push_ev(K_FETCH, 12'h005, 0, 0); push_ev(K_EXEC, 12'h005, OPC_JZ, 0);
    push_ev(K_FETCH, 12'h006, 0, 0); push_ev(K_HALT, 12'h006, 0, 0);
    run_prog("jz_not_taken");
    acc_zero = 1'b1;
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_JMP, 0);
    push_ev(K_FETCH, 12'h005, 0, 0); push_ev(K_EXEC, 12'h005, OPC_JZ, 0);
    push_ev(K_FETCH, 12'h020, 0, 0); push_ev(K_HALT, 12'h020, 0, 0);
    run_prog("jz_taken");
    acc_zero = 1'b0;

    // Four wait cycles on every fetch
    clear_mem();
    mem[0] = ins(OPC_LOAD, 12'h005);
    wait_cfg = 4;
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_LOAD, 0);
    push_ev(K_FETCH, 12'h001, 0, 0); push_ev(K_HALT, 12'h001, 0, 0);
    run_prog("wait_states");
    wait_cfg = 0;

    // Illegal opcode 1010, then restart
    clear_mem();
    mem[0] = 16'hA000;
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_HALT, 12'h000, 0, 1);
    run_prog("illegal");
    check("illegal_sticky", illegal, 1'b1);
    mem[0] = ins(OPC_LOAD, 12'h001);
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_LOAD, 0);
    push_ev(K_FETCH, 12'h001, 0, 0); push_ev(K_HALT, 12'h001, 0, 0);
    run_prog("restart_after_illegal");

    // PC wrap at 0xFFF, then asynchronous reset during EXEC
    clear_mem();
    mem[0] = ins(OPC_JMP, 12'hFFF); mem[12'hFFF] = ins(OPC_ADD, 12'h001);
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_JMP, 0);
    push_ev(K_FETCH, 12'hFFF, 0, 0); push_ev(K_EXEC, 12'hFFF, OPC_ADD, 0);
    push_ev(K_FETCH, 12'h000, 0, 0); push_ev(K_EXEC, 12'h000, OPC_JMP, 0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(negedge clk);
      if (exec_en) n++;
    end
    check("wrap_exec_count", n, 3);
    check("wrap_operand_before_reset", operand_addr, 12'hFFF);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    check("wrap_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;

`ifdef SEQ_BREAKPOINT_EN
    // Breakpoint at 3, resume from 3
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = ins(OPC_LOAD, 12'(i));
    bp_en = 1'b1; bp_addr = 12'h003;
    for (int i = 0; i < 3; i++) begin
      push_ev(K_FETCH, 12'(i), 0, 0); push_ev(K_EXEC, 12'(i), OPC_LOAD, 0);
    end
    push_ev(K_HALT, 12'h003, 0, 0);
    run_prog("bp_stop");
    for (int i = 3; i < 5; i++) begin
      push_ev(K_FETCH, 12'(i), 0, 0); push_ev(K_EXEC, 12'(i), OPC_LOAD, 0);
    end
    push_ev(K_FETCH, 12'h005, 0, 0); push_ev(K_HALT, 12'h005, 0, 0);
    run_prog("bp_resume");
    bp_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
